// File: rtl/product_arbiter.sv
// Round-robin sharing of one fixed-latency product datapath among NUM_REQ requesters.
// Issued vectors are tagged, results return in order through a credit-protected FIFO.
module product_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int PARALLELISM = 4,
    parameter int DELAY       = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  logic [NUM_REQ*PARALLELISM*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*PARALLELISM*DATA_WIDTH-1:0] req_b,
    output logic                                      prod_valid,
    input  logic                                      prod_ready,
    output logic [PARALLELISM*DATA_WIDTH-1:0]         prod_a,
    output logic [PARALLELISM*DATA_WIDTH-1:0]         prod_b,
    input  logic [PARALLELISM*DATA_WIDTH-1:0]         prod_out,
    input  logic                                      prod_out_valid,
    output logic                                      prod_out_ready,
    output logic [NUM_REQ-1:0]                        rsp_valid,
    input  logic [NUM_REQ-1:0]                        rsp_ready,
    output logic [PARALLELISM*DATA_WIDTH-1:0]         rsp_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]           in_flight,
    output logic                                      overflow_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int VW    = PARALLELISM * DATA_WIDTH;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if (DELAY < 1 || FIFO_DEPTH < 1 || NUM_REQ < 2 || NUM_REQ > 8) begin : g_param_check
        $error("product_arbiter: parameter out of range");
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_found;
    logic             issue;
    logic [CW-1:0]    credits;

    logic [IDX_W-1:0] tag_mem [FIFO_DEPTH];
    logic [PW-1:0]    tag_wr;
    logic [PW-1:0]    tag_rd;
    logic [CW-1:0]    tag_count;
    logic             tag_push;
    logic             tag_pop;

    logic [IDX_W-1:0] res_tag_mem  [FIFO_DEPTH];
    logic [VW-1:0]    res_data_mem [FIFO_DEPTH];
    logic [PW-1:0]    res_wr;
    logic [PW-1:0]    res_rd;
    logic [CW-1:0]    res_count;
    logic             res_full;
    logic             res_empty;
    logic             res_push;
    logic             res_pop;
    logic [IDX_W-1:0] head_tag;

    // Search begins one past the previous winner and wraps around.
    always_comb begin : arb
        logic [IDX_W-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Issue uses only registered credits, so a same-cycle pop cannot unblock it.
    assign issue = grant_found && prod_ready && (credits != '0);

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        prod_a = '0;
        prod_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                prod_a = req_a[i*VW +: VW];
                prod_b = req_b[i*VW +: VW];
            end
        end
    end

    assign prod_valid     = issue;
    assign prod_out_ready = 1'b1;

    assign tag_push = issue;
    assign tag_pop  = prod_out_valid && (tag_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wr    <= '0;
            tag_rd    <= '0;
            tag_count <= '0;
        end else begin
            if (tag_push) tag_wr <= ptr_inc(tag_wr);
            if (tag_pop)  tag_rd <= ptr_inc(tag_rd);
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + CW'(1);
                2'b01:   tag_count <= tag_count - CW'(1);
                default: tag_count <= tag_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem[tag_wr] <= grant_idx;
        end
    end

    assign res_full  = (res_count == CW'(FIFO_DEPTH));
    assign res_empty = (res_count == '0);
    // A result with no matching tag, or arriving while full, is dropped.
    assign res_push  = prod_out_valid && (tag_count != '0) && !res_full;
    assign head_tag  = res_tag_mem[res_rd];
    assign res_pop   = !res_empty && rsp_ready[head_tag];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_wr    <= '0;
            res_rd    <= '0;
            res_count <= '0;
        end else begin
            if (res_push) res_wr <= ptr_inc(res_wr);
            if (res_pop)  res_rd <= ptr_inc(res_rd);
            case ({res_push, res_pop})
                2'b10:   res_count <= res_count + CW'(1);
                2'b01:   res_count <= res_count - CW'(1);
                default: res_count <= res_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res_push) begin
            res_tag_mem[res_wr]  <= tag_mem[tag_rd];
            res_data_mem[res_wr] <= prod_out;
        end
    end

    assign rsp_valid = res_empty ? '0 : (NUM_REQ'(1) << head_tag);
    assign rsp_data  = res_data_mem[res_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits      <= CW'(FIFO_DEPTH);
            last_grant   <= IDX_W'(NUM_REQ - 1);
            overflow_err <= 1'b0;
        end else begin
            if (issue) begin
                last_grant <= grant_idx;
            end
            case ({issue, res_pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
            if (prod_out_valid && ((tag_count == '0) || res_full)) begin
                overflow_err <= 1'b1;
            end
        end
    end

    assign in_flight = CW'(FIFO_DEPTH) - credits;

endmodule

// File: doc/product_arbiter.md
# product_arbiter

Round-robin scheduler that shares one `product` multiplier datapath (fixed DELAY, no internal stall) among NUM_REQ requesters. It tags each issued vector, collects results in order into a credit-protected result FIFO, and steers each result back to the requester that issued it. It sits between the SpMV row engines and the `product` instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 16, element width
- PARALLELISM, 4, elements per vector
- DELAY, 2, fixed latency of the attached `product` (≥1)
- FIFO_DEPTH, 4, result FIFO entries = issue credits (≥1; ≥DELAY+2 for 1 issue/cycle)
- clk  in  1  clock; everything is synchronous to its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a, req_b  in  NUM_REQ*PARALLELISM*DATA_WIDTH  operands; requester i occupies slice i
- prod_valid  out  1  to product in_valid
- prod_ready  in  1  from product in_ready
- prod_a, prod_b  out  PARALLELISM*DATA_WIDTH  to product a/b
- prod_out  in  PARALLELISM*DATA_WIDTH  from product out
- prod_out_valid  in  1  from product valid
- prod_out_ready  out  1  to product ready; constant 1
- rsp_valid  out  NUM_REQ  result valid, one-hot on the owning requester
- rsp_ready  in  NUM_REQ  per-requester result accept
- rsp_data  out  PARALLELISM*DATA_WIDTH  shared result bus
- in_flight  out  $clog2(FIFO_DEPTH+1)  credits in use
- overflow_err  out  1  sticky protocol error

## Operation
- Credits: register `credits`, reset value FIFO_DEPTH. in_flight = FIFO_DEPTH − credits.
- Arbitration is combinational over req_valid. Search starts at index (last_grant+1) mod NUM_REQ and wraps. last_grant resets to NUM_REQ−1, so requester 0 has first priority.
- Issue condition: any req_valid && prod_ready && credits>0.
- On issue:
  - req_ready is 1 only on the granted index.
  - prod_valid = 1 and prod_a/prod_b carry the granted slice.
  - The tag (granted index) is pushed to the tag queue (depth FIFO_DEPTH).
  - last_grant ← granted index and credits decrement.
- With no issue: prod_valid = 0, req_ready = 0, last_grant holds.
- prod_a/prod_b are don't-care while prod_valid is 0.
- On prod_out_valid: pop the tag queue head and push {tag, prod_out} into the result FIFO. Ordering is in-order because product delay is fixed.
- The result FIFO head drives rsp_data, and rsp_valid[head.tag] = 1. The result pops on rsp_ready[head.tag]. rsp_ready on other indices is ignored.
- A pop returns one credit. A simultaneous issue and pop leaves credits unchanged.
- overflow_err is set and held until reset by either of:
  - prod_out_valid while the result FIFO is full.
  - prod_out_valid while the tag queue is empty.
  - In both cases the pushed data is dropped.
- A head-of-line block on rsp_ready stalls all results. Other requesters may still issue until credits reach 0.

## Timing
- Reset values: req_ready = 0, prod_valid = 0, rsp_valid = 0, in_flight = 0, overflow_err = 0. Both FIFOs are empty.
- A reset asserted mid-operation discards all tags and results immediately (asynchronously).
- The bench must not present prod_out_valid for pre-reset issues after reset is released; the product delay line is flushed externally.
- Latency:
  - Request accepted at cycle T.
  - prod_out_valid arrives at T+DELAY.
  - rsp_valid is asserted from T+DELAY+1, registered FIFO output.
- Credit visibility: a credit freed at cycle X can be used by an issue at X+1. This gives sustained 1 issue/cycle only when FIFO_DEPTH ≥ DELAY+2.
- req_ready depends combinationally on req_valid, prod_ready and credits. It never depends combinationally on rsp_ready.
- When credits=0, a pop in the same cycle does not enable an issue in that same cycle.

## Test plan
- Single requester: requester 2 issues one vector at T with rsp_ready=1 → prod_valid at T; rsp_valid = 0b0100 at T+3 (DELAY=2) with the product result; in_flight returns to 0 at T+4.
- Contention: all four req_valid held high, rsp_ready all 1, 8 cycles → grant order 0,1,2,3,0,1,2,3; one issue per cycle; each rsp_valid one-hot matches the issue order.
- Backpressure: rsp_ready = 0, requester 0 streaming → exactly 4 issues, then req_ready = 0 and in_flight = 4. Raising rsp_ready for 1 cycle → exactly one more issue, one cycle later.
- prod_ready = 0 for 3 cycles while requesters 1 and 3 are valid → no req_ready and last_grant unchanged. After release, 1 is granted before 3.
- Routing: requesters 0 and 3 alternate with distinct operands (e.g. 2.0×3.0 vs 1.5×4.0 in FP16) → rsp_data 6.0 on rsp_valid[0] and 6.0 on rsp_valid[3] in issue order. Stall rsp_ready[3] while rsp_ready[0] is 1 → the queue head blocks.
- Error/reset: inject a spurious prod_out_valid with in_flight = 0 → overflow_err = 1, sticky. Assert rst_n low mid-stream with 3 in flight → all outputs are at reset values immediately, and traffic resumes cleanly after release.
